clock_gen_multi: RTL and testbench
==================================

Name: clock_gen_multi

Overview:
Parameterised, fully synchronous clock-generation block. It replaces free-running delay-based oscillators with NUM_CH programmable divided-clock channels, all derived from the single system clock.
- Each channel produces a 50%-duty square wave and a one-cycle rising-edge tick.
- Each channel has a runtime-writable divisor and glitch-free stop/start.
- A watchdog counter runs on the last channel's ticks.
- Sits at the top of the design; its outputs feed low-speed, sleep and watchdog logic.

Parameters:
- NUM_CH, 3, number of divided-clock channels (1..16).
- DIV_W, 16, width of each channel's half-period divisor.
- WDT_W, 16, width of the watchdog counter and limit.
- DIV_RST, 1, divisor loaded into every channel at reset.
- SEL_W, derived, max(1, clog2(NUM_CH)), not user-set.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ch_enable  in  NUM_CH  per-channel run request.
- div_wr  in  1  single-cycle divisor write strobe.
- div_sel  in  SEL_W  channel index for div_wr.
- div_value  in  DIV_W  new half-period divisor.
- div_pending  out  NUM_CH  write accepted, not yet applied.
- ch_out  out  NUM_CH  divided square-wave outputs (registered).
- ch_tick  out  NUM_CH  one-cycle pulse coincident with each ch_out rise.
- ch_running  out  NUM_CH  channel is counting.
- wdt_kick  in  1  clears the watchdog counter.
- wdt_limit  in  WDT_W  timeout threshold in ticks; 0 disables the watchdog.
- wdt_count  out  WDT_W  current watchdog count.
- wdt_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (async assert, sync release): all outputs 0; every active divisor = DIV_RST; counters 0; pending flags clear.
- Per-channel state machine:
  - States: IDLE, RUN, STOPPING.
  - IDLE: ch_out=0, cnt=0. If ch_enable=1, go to RUN next cycle.
  - RUN: cnt increments each cycle. When cnt == div-1: cnt<=0 and ch_out toggles.
  - Period = 2*div cycles: high for div cycles, low for div cycles.
  - A divisor value of 0 is treated as 1.
  - ch_enable=0 in RUN with ch_out=0: go to IDLE next cycle.
  - ch_enable=0 in RUN with ch_out=1: go to STOPPING.
  - STOPPING: keep counting until the high->low toggle, then IDLE. No truncated high phase.
  - ch_enable re-asserted in STOPPING: return to RUN with no glitch.
- First rise: with div=D, enable sampled high at cycle 0 puts the channel in RUN at cycle 1, and ch_out rises at cycle 1+D.
- ch_tick=1 exactly in the cycles where ch_out goes 0->1. It is registered alongside ch_out.
- ch_running=1 in RUN and STOPPING.
- Divisor update:
  - div_wr latches div_value into channel div_sel's pending register and sets div_pending next cycle.
  - If div_sel >= NUM_CH, the write is ignored.
  - In IDLE, pending is applied at the next cycle and div_pending clears.
  - In RUN/STOPPING, pending is applied at the high->low toggle (full-period boundary). cnt restarts at 0 with the new divisor.
  - A second write before apply overwrites the pending value; only the last value applies.
  - If a write coincides with a boundary, the boundary applies the value pending before the write. The new value becomes pending for the next boundary.
- Watchdog:
  - wdt_count increments on ch_tick[NUM_CH-1] and saturates at all-ones.
  - wdt_kick clears wdt_count to 0 and wins over a same-cycle tick.
  - wdt_timeout is set in the cycle after wdt_count reaches wdt_limit, when wdt_limit != 0.
  - wdt_timeout is sticky; it clears only on reset. wdt_kick does not clear it.
  - Lowering wdt_limit to or below the current count sets wdt_timeout next cycle.
- Reset mid-operation: all channels go immediately to IDLE with outputs 0. Pending writes are discarded.

Test Plan:
- Reset, then ch_enable=001 with default div 1 -> ch_out[0] toggles every cycle (period 2); ch_tick[0] is 1 every 2nd cycle; other channels stay 0.
- Write div 5 to ch1 while idle, then enable -> first rise 6 cycles after enable; high 5, low 5; div_pending high for exactly 1 cycle.
- ch2 running at div 4; write 2 mid-high-phase -> current period completes at 4/4; next period is 2/2; div_pending holds until the falling edge.
- Deassert ch_enable during ch0 high phase (div 8, 3 cycles in) -> high lasts the full 8 cycles, then ch_out=0 and ch_running=0; no glitches.
- wdt_limit=3 with last channel at div 1 and no kick -> wdt_timeout=1 one cycle after the 3rd tick. Repeat with a kick every 2 ticks -> wdt_timeout stays 0; kick and tick in the same cycle leave count 0.
- Assert reset while all channels run with writes pending -> all outputs 0 asynchronously; after release, divisors read back DIV_RST behaviour (period 2).

Source files
------------

// File: rtl/clock_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : clock_gen_multi
// Brief    : NUM_CH programmable 50%-duty divided clocks derived from clk,
//            each with a rising-edge tick, glitch-free stop/start and
//            period-boundary divisor updates, plus a watchdog counter
//            advanced by the last channel's ticks.
// Revision : 1.0 - initial release
// ============================================================================
module clock_gen_multi #(
    parameter int NUM_CH  = 3,
    parameter int DIV_W   = 16,
    parameter int WDT_W   = 16,
    parameter int DIV_RST = 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_CH-1:0]                             ch_enable,
    input  logic                                          div_wr,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] div_sel,
    input  logic [DIV_W-1:0]                              div_value,
    output logic [NUM_CH-1:0]                             div_pending,
    output logic [NUM_CH-1:0]                             ch_out,
    output logic [NUM_CH-1:0]                             ch_tick,
    output logic [NUM_CH-1:0]                             ch_running,
    input  logic                                          wdt_kick,
    input  logic [WDT_W-1:0]                              wdt_limit,
    output logic [WDT_W-1:0]                              wdt_count,
    output logic                                          wdt_timeout
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [DIV_W-1:0] c_div_rst = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0] c_div_one = DIV_W'(1);

    // STOPPING is a run state that only finishes the current high phase.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } ch_state_t;

    logic [WDT_W-1:0] r_wdt_count;
    logic             r_wdt_timeout;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            ch_state_t        r_state;
            ch_state_t        w_state_nxt;
            logic [DIV_W-1:0] r_cnt;
            logic [DIV_W-1:0] w_cnt_nxt;
            logic [DIV_W-1:0] r_div;
            logic [DIV_W-1:0] w_div_nxt;
            logic [DIV_W-1:0] r_pend_val;
            logic [DIV_W-1:0] w_pend_val_nxt;
            logic             r_pend;
            logic             w_pend_nxt;
            logic             r_out;
            logic             w_out_nxt;
            logic             r_tick;
            logic             w_tick_nxt;
            logic             w_apply;
            logic             w_wr;
            logic             w_wrap;
            logic [DIV_W-1:0] w_div_eff;

            // A programmed divisor of zero behaves as one.
            assign w_div_eff = (r_div == '0) ? c_div_one : r_div;
            assign w_wrap    = (r_cnt == (w_div_eff - c_div_one));
            // Out-of-range selects match no channel, so such writes vanish.
            assign w_wr      = div_wr && (div_sel == SEL_W'(gi));

            // Next-state, counter, output and divisor-update decode
            always_comb begin
                w_state_nxt    = r_state;
                w_cnt_nxt      = r_cnt;
                w_out_nxt      = r_out;
                w_tick_nxt     = 1'b0;
                w_apply        = 1'b0;
                w_div_nxt      = r_div;
                w_pend_nxt     = r_pend;
                w_pend_val_nxt = r_pend_val;

                case (r_state)
                    ST_IDLE: begin
                        w_cnt_nxt = '0;
                        w_out_nxt = 1'b0;
                        w_apply   = r_pend;
                        if (ch_enable[gi]) begin
                            w_state_nxt = ST_RUN;
                        end
                    end
                    ST_RUN, ST_STOPPING: begin
                        if (!ch_enable[gi] && !r_out) begin
                            // Low phase: stopping here cannot truncate a pulse.
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            if (w_wrap) begin
                                w_cnt_nxt  = '0;
                                w_out_nxt  = ~r_out;
                                w_tick_nxt = ~r_out;
                                // Falling edge closes a full period.
                                w_apply    = r_out & r_pend;
                            end else begin
                                w_cnt_nxt = r_cnt + c_div_one;
                            end
                            if (ch_enable[gi]) begin
                                w_state_nxt = ST_RUN;
                            end else if (w_wrap && r_out) begin
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_state_nxt = ST_STOPPING;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_out_nxt   = 1'b0;
                    end
                endcase

                // The apply uses the value held before any same-cycle write;
                // that write then becomes pending for the next boundary.
                if (w_apply) begin
                    w_div_nxt  = r_pend_val;
                    w_pend_nxt = 1'b0;
                end
                if (w_wr) begin
                    w_pend_val_nxt = div_value;
                    w_pend_nxt     = 1'b1;
                end
            end

            // Channel registers; reset discards pending writes
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state    <= ST_IDLE;
                    r_cnt      <= '0;
                    r_div      <= c_div_rst;
                    r_pend_val <= '0;
                    r_pend     <= 1'b0;
                    r_out      <= 1'b0;
                    r_tick     <= 1'b0;
                end else begin
                    r_state    <= w_state_nxt;
                    r_cnt      <= w_cnt_nxt;
                    r_div      <= w_div_nxt;
                    r_pend_val <= w_pend_val_nxt;
                    r_pend     <= w_pend_nxt;
                    r_out      <= w_out_nxt;
                    r_tick     <= w_tick_nxt;
                end
            end

            assign ch_out[gi]      = r_out;
            assign ch_tick[gi]     = r_tick;
            assign ch_running[gi]  = (r_state != ST_IDLE);
            assign div_pending[gi] = r_pend;
        end
    endgenerate

    // Watchdog count: kick wins over a tick, count saturates at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdt_count <= '0;
        end else if (wdt_kick) begin
            r_wdt_count <= '0;
        end else if (ch_tick[NUM_CH-1] && (r_wdt_count != '1)) begin
            r_wdt_count <= r_wdt_count + WDT_W'(1);
        end
    end

    // Sticky timeout; >= also catches a limit lowered below the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdt_timeout <= 1'b0;
        end else if ((wdt_limit != '0) && (r_wdt_count >= wdt_limit)) begin
            r_wdt_timeout <= 1'b1;
        end
    end

    assign wdt_count   = r_wdt_count;
    assign wdt_timeout = r_wdt_timeout;

endmodule
`default_nettype wire

// File: tb/tb_clock_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_gen_multi
// Brief    : Self-checking bench for clock_gen_multi. A period-position model
//            of each channel and a tick-count model of the watchdog predict
//            every output each cycle; directed scenarios add fixed checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_gen_multi;

    localparam int NUM_CH  = 3;
    localparam int DIV_W   = 16;
    localparam int WDT_W   = 16;
    localparam int DIV_RST = 1;
    localparam int SEL_W   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] ch_enable;
    logic              div_wr;
    logic [SEL_W-1:0]  div_sel;
    logic [DIV_W-1:0]  div_value;
    logic [NUM_CH-1:0] div_pending;
    logic [NUM_CH-1:0] ch_out;
    logic [NUM_CH-1:0] ch_tick;
    logic [NUM_CH-1:0] ch_running;
    logic              wdt_kick;
    logic [WDT_W-1:0]  wdt_limit;
    logic [WDT_W-1:0]  wdt_count;
    logic              wdt_timeout;

    int errors = 0;
    int checks = 0;

    // Reference model: position inside the 2*div period while running
    int m_run [NUM_CH];
    int m_pos [NUM_CH];
    int m_div [NUM_CH];
    int m_pend[NUM_CH];
    int m_pval[NUM_CH];
    int m_tick[NUM_CH];
    int m_wcnt;
    int m_wto;

    clock_gen_multi #(
        .NUM_CH (NUM_CH),
        .DIV_W  (DIV_W),
        .WDT_W  (WDT_W),
        .DIV_RST(DIV_RST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ch_enable  (ch_enable),
        .div_wr     (div_wr),
        .div_sel    (div_sel),
        .div_value  (div_value),
        .div_pending(div_pending),
        .ch_out     (ch_out),
        .ch_tick    (ch_tick),
        .ch_running (ch_running),
        .wdt_kick   (wdt_kick),
        .wdt_limit  (wdt_limit),
        .wdt_count  (wdt_count),
        .wdt_timeout(wdt_timeout)
    );

    always #5 clk = ~clk;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_run[i]  = 0;
            m_pos[i]  = 0;
            m_div[i]  = DIV_RST;
            m_pend[i] = 0;
            m_pval[i] = 0;
            m_tick[i] = 0;
        end
        m_wcnt = 0;
        m_wto  = 0;
    endtask

    // One rising clock edge of the model, from the inputs the DUT samples
    task automatic model_edge();
        int wmax;
        int nto;
        wmax = (1 << WDT_W) - 1;
        nto  = m_wto;
        if ((wdt_limit != 0) && (m_wcnt >= int'(wdt_limit))) nto = 1;
        if (wdt_kick) m_wcnt = 0;
        else if ((m_tick[NUM_CH-1] != 0) && (m_wcnt < wmax)) m_wcnt = m_wcnt + 1;
        m_wto = nto;

        for (int i = 0; i < NUM_CH; i++) begin
            int e;
            bit en;
            bit wr;
            bit apply;
            e         = eff(m_div[i]);
            en        = ch_enable[i];
            wr        = div_wr && (int'(div_sel) == i);
            apply     = 1'b0;
            m_tick[i] = 0;
            if (m_run[i] == 0) begin
                apply = (m_pend[i] != 0);
                if (en) begin
                    m_run[i] = 1;
                    m_pos[i] = 0;
                end
            end else if (!en && (m_pos[i] < e)) begin
                m_run[i] = 0;
                m_pos[i] = 0;
            end else begin
                m_pos[i] = m_pos[i] + 1;
                if (m_pos[i] == e) m_tick[i] = 1;
                if (m_pos[i] == 2 * e) begin
                    m_pos[i] = 0;
                    apply    = (m_pend[i] != 0);
                    if (!en) m_run[i] = 0;
                end
            end
            if (apply) begin
                m_div[i]  = m_pval[i];
                m_pend[i] = 0;
            end
            if (wr) begin
                m_pval[i] = int'(div_value);
                m_pend[i] = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [NUM_CH-1:0] e_out;
        logic [NUM_CH-1:0] e_tick;
        logic [NUM_CH-1:0] e_run;
        logic [NUM_CH-1:0] e_pend;
        for (int i = 0; i < NUM_CH; i++) begin
            e_out[i]  = (m_run[i] != 0) && (m_pos[i] >= eff(m_div[i]));
            e_tick[i] = (m_tick[i] != 0);
            e_run[i]  = (m_run[i] != 0);
            e_pend[i] = (m_pend[i] != 0);
        end
        chk({tag, ":ch_out"},      64'(ch_out),      64'(e_out));
        chk({tag, ":ch_tick"},     64'(ch_tick),     64'(e_tick));
        chk({tag, ":ch_running"},  64'(ch_running),  64'(e_run));
        chk({tag, ":div_pending"}, 64'(div_pending), 64'(e_pend));
        chk({tag, ":wdt_count"},   64'(wdt_count),   64'(m_wcnt));
        chk({tag, ":wdt_timeout"}, 64'(wdt_timeout), 64'(m_wto));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic wr(input int sel, input int val);
        div_wr    = 1'b1;
        div_sel   = SEL_W'(sel);
        div_value = DIV_W'(val);
        step("wr");
        div_wr    = 1'b0;
    endtask

    task automatic wait_rise(input int ch, input int max_cyc, input string tag);
        int n;
        n = 0;
        while (!ch_out[ch] && (n < max_cyc)) begin
            step(tag);
            n++;
        end
        chk({tag, ":rise_seen"}, 64'(ch_out[ch]), 64'(1));
    endtask

    // Reset asserted between clock edges; outputs must clear at once
    task automatic async_reset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all({tag, ":async"});
        chk({tag, ":out_zero"}, 64'(ch_out), 64'(0));
        steps({tag, ":held"}, 2);
        reset = 1'b0;
    endtask

    initial begin
        int hi;
        int n;

        reset     = 1'b1;
        ch_enable = '0;
        div_wr    = 1'b0;
        div_sel   = '0;
        div_value = '0;
        wdt_kick  = 1'b0;
        wdt_limit = '0;
        model_reset();
        steps("reset", 2);
        reset = 1'b0;
        step("post_reset");

        // Channel 0 at the reset divisor: period 2
        ch_enable = 3'b001;
        step("en0");
        chk("en0_running", 64'(ch_running[0]), 64'(1));
        chk("en0_low", 64'(ch_out[0]), 64'(0));
        step("en0");
        chk("en0_rise", 64'(ch_out[0]), 64'(1));
        chk("en0_tick", 64'(ch_tick[0]), 64'(1));
        step("en0");
        chk("en0_fall", 64'(ch_out[0]), 64'(0));
        chk("en0_others", 64'(ch_out[2:1]), 64'(0));
        steps("en0", 8);
        ch_enable = 3'b000;
        steps("stop0", 4);

        // Divisor 5 written while idle, then enable
        wr(1, 5);
        chk("wr1_pending", 64'(div_pending[1]), 64'(1));
        step("wr1");
        chk("wr1_applied", 64'(div_pending[1]), 64'(0));
        ch_enable = 3'b010;
        for (int i = 0; i < 5; i++) begin
            step("ch1_first");
            chk("ch1_pre_rise", 64'(ch_out[1]), 64'(0));
        end
        step("ch1_first");
        chk("ch1_rise6", 64'(ch_out[1]), 64'(1));
        chk("ch1_tick6", 64'(ch_tick[1]), 64'(1));
        steps("ch1_run", 20);

        // Channel 2 at div 4, rewritten to 2 during a high phase
        wr(2, 4);
        step("ch2_apply");
        ch_enable = 3'b110;
        wait_rise(2, 20, "ch2_rise");
        steps("ch2_high", 2);
        wr(2, 2);
        chk("ch2_pending", 64'(div_pending[2]), 64'(1));
        n = 0;
        while (ch_out[2] && (n < 10)) begin
            chk("ch2_hold_pending", 64'(div_pending[2]), 64'(1));
            step("ch2_to_fall");
            n++;
        end
        chk("ch2_fallen", 64'(ch_out[2]), 64'(0));
        chk("ch2_pending_clear", 64'(div_pending[2]), 64'(0));
        step("ch2_low2");
        chk("ch2_low2_out", 64'(ch_out[2]), 64'(0));
        step("ch2_rise2");
        chk("ch2_newdiv_rise", 64'(ch_out[2]), 64'(1));
        steps("ch2_run", 12);

        // Channel 0 at div 8, disabled three cycles into the high phase
        wr(0, 8);
        step("ch0_apply");
        ch_enable = 3'b111;
        wait_rise(0, 30, "ch0_rise");
        steps("ch0_high", 2);
        ch_enable[0] = 1'b0;
        hi = 3;
        n  = 0;
        while (n < 20) begin
            step("ch0_stopping");
            n++;
            if (ch_out[0]) hi++;
            else break;
        end
        chk("ch0_full_high", 64'(hi), 64'(8));
        chk("ch0_stopped", 64'(ch_running[0]), 64'(0));
        steps("ch0_idle", 3);

        // Watchdog timeout with limit 3, no kicks
        ch_enable = 3'b000;
        steps("wdt_prep", 20);
        wr(2, 1);
        step("wdt_prep");
        wdt_kick = 1'b1;
        step("wdt_kick");
        wdt_kick  = 1'b0;
        wdt_limit = WDT_W'(3);
        ch_enable = 3'b100;
        steps("wdt_run", 12);
        chk("wdt_timed_out", 64'(wdt_timeout), 64'(1));

        // Kicks every two ticks keep the watchdog quiet
        async_reset("wdt_rst");
        for (int c = 0; c < 40; c++) begin
            wdt_kick = ((c % 4) == 3);
            step("wdt_kicked");
        end
        wdt_kick = 1'b0;
        chk("wdt_no_timeout", 64'(wdt_timeout), 64'(0));
        n = 0;
        while (!ch_tick[2] && (n < 10)) begin
            step("wdt_find_tick");
            n++;
        end
        chk("wdt_tick_seen", 64'(ch_tick[2]), 64'(1));
        wdt_kick = 1'b1;
        step("wdt_kick_tick");
        wdt_kick = 1'b0;
        chk("wdt_kick_wins", 64'(wdt_count), 64'(0));

        // Randomised traffic against the model
        for (int c = 0; c < 600; c++) begin
            int k;
            if ($urandom_range(7) == 0) begin
                k = int'($urandom_range(NUM_CH - 1));
                ch_enable[k] = ~ch_enable[k];
            end
            div_wr    = ($urandom_range(9) == 0);
            div_sel   = SEL_W'($urandom_range(3));
            div_value = DIV_W'($urandom_range(5));
            wdt_kick  = ($urandom_range(11) == 0);
            if ($urandom_range(49) == 0) wdt_limit = WDT_W'($urandom_range(12));
            step("rand");
        end
        div_wr   = 1'b0;
        wdt_kick = 1'b0;

        // Reset while running with writes pending
        ch_enable = 3'b111;
        wr(0, 7);
        wr(1, 9);
        steps("pre_rst", 3);
        wr(2, 6);
        async_reset("mid_rst");
        step("post_rst_run");
        step("post_rst_rise");
        chk("post_rst_period2", 64'(ch_out), 64'(3'b111));
        chk("post_rst_no_pending", 64'(div_pending), 64'(0));
        steps("post_rst", 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
